tlb_refill_ctrl: RTL and testbench
==================================

# tlb_refill_ctrl

Miss/refill sequencer for the 32-entry fully-associative TLB. It forwards hit indices to the 32-way tree pseudo-LRU (`lru`) and tracks per-entry valid bits. On a miss it selects a victim: the lowest-index invalid entry if one exists, otherwise the LRU victim. It then runs a request/response handshake with the page-table walker and writes the returned translation into the chosen entry. It sits between the TLB lookup stage, the `lru` instance and the PTW.

## Interface
Parameters:
- VPN_W, 20, virtual page number width
- PPN_W, 22, physical page number width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- lookup_valid  in  1  TLB lookup result valid this cycle
- lookup_hit  in  1  lookup hit
- hit_idx  in  5  index of hitting entry
- lookup_vpn  in  VPN_W  VPN of current lookup
- flush  in  1  invalidate all entries (single-cycle pulse)
- lru_access  out  1  to lru.access
- lru_addr_access  out  5  to lru.addr_access
- lru_compare  out  1  to lru.compare
- lru_victim  in  5  from lru.lru_addr (registered; valid one cycle after compare)
- ptw_req_valid  out  1  walk request
- ptw_req_ready  in  1  PTW accepts request
- ptw_req_vpn  out  VPN_W  VPN to walk
- ptw_resp_valid  in  1  walk response (single-cycle pulse)
- ptw_resp_ppn  in  PPN_W  translated PPN
- ptw_resp_fault  in  1  walk faulted
- tlb_we  out  1  TLB entry write strobe
- tlb_widx  out  5  entry index written
- tlb_wvpn  out  VPN_W  tag written
- tlb_wppn  out  PPN_W  data written
- entry_valid  out  32  per-entry valid vector
- busy  out  1  refill in progress; upstream stalls lookups
- miss_done  out  1  one-cycle pulse, refill complete
- miss_fault  out  1  one-cycle pulse with miss_done when walk faulted
- miss_ppn  out  PPN_W  PPN returned; valid with miss_done

## Operation
- FSM states: IDLE, SEL, CAPT, REQ, WAIT, FILL.
- IDLE, lookup_valid & lookup_hit: combinationally drive lru_access=1 and lru_addr_access=hit_idx in the same cycle. No state change.
- IDLE, lookup_valid & !lookup_hit: latch lookup_vpn into miss_vpn and go to SEL.
  - If entry_valid != 32'hFFFFFFFF, latch the lowest-index zero bit as victim and go directly to REQ instead (skip SEL/CAPT).
- SEL: lru_compare=1 → CAPT.
- CAPT: lru_compare=1; latch lru_victim as victim → REQ.
- REQ: ptw_req_valid=1 and ptw_req_vpn=miss_vpn, held stable until ptw_req_valid & ptw_req_ready → WAIT.
- WAIT: on ptw_resp_valid, latch ptw_resp_ppn and ptw_resp_fault → FILL.
- FILL, one cycle, in all cases: miss_done=1, miss_ppn=latched PPN, next state IDLE. The write and LRU update depend on the fault and flush status:
  - No fault, no pending flush: tlb_we=1, tlb_widx=victim, tlb_wvpn=miss_vpn, tlb_wppn=PPN. Also lru_access=1 with lru_addr_access=victim. entry_valid[victim] is set next cycle.
  - Fault: tlb_we=0, lru_access=0, miss_fault=1.
  - Pending flush: tlb_we=0, lru_access=0, miss_fault=0. The pending flush is applied at this point.
- Flush:
  - In IDLE: entry_valid cleared next cycle.
  - In any other state: set flush_pending, which is applied in FILL and then cleared.
  - A flush coinciding with a miss in IDLE takes priority: the vector is cleared and the miss proceeds with victim 0.
- lookup_valid is ignored while busy. A hit and a miss are never simultaneous.
- lru_compare=0 outside SEL/CAPT. lru_access is only asserted in IDLE (hit) or FILL.

## Timing
- Reset values: state IDLE, entry_valid=0, flush_pending=0, all outputs 0, miss_ppn=0, victim=0.
- busy=1 in every state except IDLE, combinationally from state.
- Miss with an invalid entry available: IDLE→REQ. The earliest ptw_req_valid is the cycle after the miss.
- Miss with all entries valid: IDLE→SEL→CAPT→REQ. ptw_req_valid first asserts 3 cycles after the miss.
- With ready=1 and a response the next cycle: REQ 1 cycle, WAIT 1 cycle, FILL 1 cycle. busy deasserts the cycle after FILL.
- A response arriving in REQ (before the handshake) is ignored.
- rst mid-refill returns to IDLE the next cycle with no write and no done pulse. Any outstanding PTW response after reset is ignored.

## Test plan
- After reset, a miss on VPN 0x12345 → victim 0, ptw_req_vpn=0x12345. Response PPN 0x3ABCD gives tlb_we with widx=0 and wppn=0x3ABCD; entry_valid=32'h1.
- Fill all 32 entries, then hit indices 0..31 in order, then miss → SEL/CAPT with lru_compare high for 2 cycles. Victim must equal the tree's lru_addr, and tlb_widx must match it.
- Hold ptw_req_ready=0 for 5 cycles → ptw_req_valid and ptw_req_vpn stay stable. The handshake completes on the first ready cycle.
- ptw_resp_fault=1 → miss_done and miss_fault pulse together; tlb_we=0, lru_access=0, entry_valid unchanged.
- Flush pulse during WAIT, then response PPN 0x1 → miss_done=1, miss_ppn=0x1, tlb_we=0, entry_valid=0 after FILL.
- Assert rst in WAIT → busy=0 and entry_valid=0 next cycle. A response pulse one cycle later produces no tlb_we and no miss_done.

Source files
------------

// File: rtl/tlb_refill_ctrl.sv
// tlb_refill_ctrl
//   Miss/refill sequencer for a 32-entry fully-associative TLB.
//   Forwards lookup hits to the tree pseudo-LRU, keeps the per-entry valid
//   vector, picks a victim on a miss (lowest free entry, else the LRU's
//   choice), walks the page table through a req/resp handshake and writes
//   the returned translation back into the victim entry.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   lookup_valid/hit/hit_idx    lookup stage result
//   lookup_vpn                  VPN of the current lookup
//   flush                       invalidate all entries (pulse)
//   lru_access/addr_access      touch an entry in the LRU tree
//   lru_compare, lru_victim     victim query; answer is registered in lru
//   ptw_req_*                   walk request handshake
//   ptw_resp_*                  walk response (pulse)
//   tlb_we/widx/wvpn/wppn       TLB entry write port
//   entry_valid                 per-entry valid vector
//   busy                        refill in progress
//   miss_done/miss_fault/ppn    refill completion report
module tlb_refill_ctrl #(
  parameter int unsigned VPN_W = 20,
  parameter int unsigned PPN_W = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lookup_valid,
  input  logic             lookup_hit,
  input  logic [4:0]       hit_idx,
  input  logic [VPN_W-1:0] lookup_vpn,
  input  logic             flush,
  output logic             lru_access,
  output logic [4:0]       lru_addr_access,
  output logic             lru_compare,
  input  logic [4:0]       lru_victim,
  output logic             ptw_req_valid,
  input  logic             ptw_req_ready,
  output logic [VPN_W-1:0] ptw_req_vpn,
  input  logic             ptw_resp_valid,
  input  logic [PPN_W-1:0] ptw_resp_ppn,
  input  logic             ptw_resp_fault,
  output logic             tlb_we,
  output logic [4:0]       tlb_widx,
  output logic [VPN_W-1:0] tlb_wvpn,
  output logic [PPN_W-1:0] tlb_wppn,
  output logic [31:0]      entry_valid,
  output logic             busy,
  output logic             miss_done,
  output logic             miss_fault,
  output logic [PPN_W-1:0] miss_ppn
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEL  = 3'd1,
    CAPT = 3'd2,
    REQ  = 3'd3,
    WAIT = 3'd4,
    FILL = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [31:0]        r_entry_valid;
  logic               r_flush_pending;
  logic [VPN_W-1:0]   r_miss_vpn;
  logic [4:0]         r_victim;
  logic [PPN_W-1:0]   r_ppn;
  logic               r_fault;

  logic               w_full;
  logic               w_found;
  logic [4:0]         w_free_idx;
  logic               w_miss;
  logic               w_flush_apply;

  assign w_full        = &r_entry_valid;
  assign w_miss        = lookup_valid & ~lookup_hit;
  // A flush landing in FILL itself is treated like a pending one.
  assign w_flush_apply = r_flush_pending | flush;

  assign entry_valid = r_entry_valid;
  assign busy        = (r_state != IDLE);
  assign miss_ppn    = r_ppn;

  // Lowest-index invalid entry.
  always_comb begin
    w_found    = 1'b0;
    w_free_idx = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (!w_found && !r_entry_valid[i]) begin
        w_found    = 1'b1;
        w_free_idx = 5'(i);
      end
    end
  end

  always_comb begin
    w_next          = r_state;
    lru_access      = 1'b0;
    lru_addr_access = '0;
    lru_compare     = 1'b0;
    ptw_req_valid   = 1'b0;
    ptw_req_vpn     = '0;
    tlb_we          = 1'b0;
    tlb_widx        = '0;
    tlb_wvpn        = '0;
    tlb_wppn        = '0;
    miss_done       = 1'b0;
    miss_fault      = 1'b0;
    case (r_state)
      IDLE: begin
        if (lookup_valid && lookup_hit) begin
          lru_access      = 1'b1;
          lru_addr_access = hit_idx;
        end else if (w_miss) begin
          // A simultaneous flush empties the vector, so a free entry exists.
          w_next = (flush || !w_full) ? REQ : SEL;
        end
      end
      SEL: begin
        lru_compare = 1'b1;
        w_next      = CAPT;
      end
      CAPT: begin
        lru_compare = 1'b1;
        w_next      = REQ;
      end
      REQ: begin
        ptw_req_valid = 1'b1;
        ptw_req_vpn   = r_miss_vpn;
        if (ptw_req_ready) w_next = WAIT;
      end
      WAIT: begin
        if (ptw_resp_valid) w_next = FILL;
      end
      FILL: begin
        miss_done = 1'b1;
        w_next    = IDLE;
        if (!w_flush_apply) begin
          if (r_fault) begin
            miss_fault = 1'b1;
          end else begin
            tlb_we          = 1'b1;
            tlb_widx        = r_victim;
            tlb_wvpn        = r_miss_vpn;
            tlb_wppn        = r_ppn;
            lru_access      = 1'b1;
            lru_addr_access = r_victim;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_entry_valid   <= '0;
      r_flush_pending <= 1'b0;
      r_miss_vpn      <= '0;
      r_victim        <= '0;
      r_ppn           <= '0;
      r_fault         <= 1'b0;
    end else begin
      r_state <= w_next;
      if (flush && r_state != IDLE && r_state != FILL) r_flush_pending <= 1'b1;
      case (r_state)
        IDLE: begin
          if (flush) r_entry_valid <= '0;
          if (w_miss) begin
            r_miss_vpn <= lookup_vpn;
            if (flush)        r_victim <= '0;
            else if (!w_full) r_victim <= w_free_idx;
          end
        end
        CAPT: r_victim <= lru_victim;
        WAIT: begin
          if (ptw_resp_valid) begin
            r_ppn   <= ptw_resp_ppn;
            r_fault <= ptw_resp_fault;
          end
        end
        FILL: begin
          if (w_flush_apply) begin
            r_entry_valid   <= '0;
            r_flush_pending <= 1'b0;
          end else if (!r_fault) begin
            r_entry_valid[r_victim] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_refill_ctrl.sv
// Directed bench for tlb_refill_ctrl. Inputs change on the falling edge and
// outputs are sampled 1 time unit later, away from the rising edge.
module tb_tlb_refill_ctrl;
  localparam int unsigned VPN_W = 20;
  localparam int unsigned PPN_W = 22;

  logic             clk = 1'b0;
  logic             rst;
  logic             lookup_valid;
  logic             lookup_hit;
  logic [4:0]       hit_idx;
  logic [VPN_W-1:0] lookup_vpn;
  logic             flush;
  logic             lru_access;
  logic [4:0]       lru_addr_access;
  logic             lru_compare;
  logic [4:0]       lru_victim = 5'd0;
  logic             ptw_req_valid;
  logic             ptw_req_ready;
  logic [VPN_W-1:0] ptw_req_vpn;
  logic             ptw_resp_valid;
  logic [PPN_W-1:0] ptw_resp_ppn;
  logic             ptw_resp_fault;
  logic             tlb_we;
  logic [4:0]       tlb_widx;
  logic [VPN_W-1:0] tlb_wvpn;
  logic [PPN_W-1:0] tlb_wppn;
  logic [31:0]      entry_valid;
  logic             busy;
  logic             miss_done;
  logic             miss_fault;
  logic [PPN_W-1:0] miss_ppn;

  int n_pass  = 0;
  int n_total = 0;

  tlb_refill_ctrl #(.VPN_W(VPN_W), .PPN_W(PPN_W)) dut (
    .clk(clk), .rst(rst),
    .lookup_valid(lookup_valid), .lookup_hit(lookup_hit), .hit_idx(hit_idx),
    .lookup_vpn(lookup_vpn), .flush(flush),
    .lru_access(lru_access), .lru_addr_access(lru_addr_access),
    .lru_compare(lru_compare), .lru_victim(lru_victim),
    .ptw_req_valid(ptw_req_valid), .ptw_req_ready(ptw_req_ready),
    .ptw_req_vpn(ptw_req_vpn), .ptw_resp_valid(ptw_resp_valid),
    .ptw_resp_ppn(ptw_resp_ppn), .ptw_resp_fault(ptw_resp_fault),
    .tlb_we(tlb_we), .tlb_widx(tlb_widx), .tlb_wvpn(tlb_wvpn), .tlb_wppn(tlb_wppn),
    .entry_valid(entry_valid), .busy(busy), .miss_done(miss_done),
    .miss_fault(miss_fault), .miss_ppn(miss_ppn)
  );

  always #5 clk = ~clk;

  // Stand-in for the LRU tree: after hits 0..31 then 0, the tree victim is 16.
  // Answers are registered, so 16 only appears the cycle after a compare.
  always @(posedge clk) lru_victim <= lru_compare ? 5'd16 : 5'd31;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // One-cycle miss lookup; returns one negedge later (state REQ or SEL).
  task automatic miss(input logic [VPN_W-1:0] vpn);
    lookup_valid = 1'b1;
    lookup_hit   = 1'b0;
    lookup_vpn   = vpn;
    step();
    lookup_valid = 1'b0;
  endtask

  task automatic wait_req();
    for (int k = 0; k < 8; k++) begin
      if (ptw_req_valid) break;
      step();
    end
    chk("req_timeout", ptw_req_valid, 1'b1);
  endtask

  // From REQ: handshake at once, respond next cycle; returns inside FILL.
  task automatic walk(input logic [PPN_W-1:0] ppn, input logic fault);
    ptw_req_ready = 1'b1;
    step();
    ptw_req_ready  = 1'b0;
    ptw_resp_valid = 1'b1;
    ptw_resp_ppn   = ppn;
    ptw_resp_fault = fault;
    step();
    ptw_resp_valid = 1'b0;
    ptw_resp_fault = 1'b0;
  endtask

  initial begin
    rst = 1'b1; lookup_valid = 1'b0; lookup_hit = 1'b0; hit_idx = '0;
    lookup_vpn = '0; flush = 1'b0; ptw_req_ready = 1'b0; ptw_resp_valid = 1'b0;
    ptw_resp_ppn = '0; ptw_resp_fault = 1'b0;
    repeat (2) step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", entry_valid, 32'h0);
    chk("rst_req", ptw_req_valid, 1'b0);
    chk("rst_ppn", miss_ppn, '0);
    chk("rst_we", tlb_we, 1'b0);
    rst = 1'b0;
    step();

    // First miss: free entry 0, request the very next cycle.
    miss(20'h12345);
    chk("m1_req", ptw_req_valid, 1'b1);
    chk("m1_vpn", ptw_req_vpn, 20'h12345);
    chk("m1_busy", busy, 1'b1);
    walk(22'h3ABCD, 1'b0);
    chk("m1_we", tlb_we, 1'b1);
    chk("m1_widx", tlb_widx, 5'd0);
    chk("m1_wvpn", tlb_wvpn, 20'h12345);
    chk("m1_wppn", tlb_wppn, 22'h3ABCD);
    chk("m1_done", {miss_done, miss_fault}, 2'b10);
    chk("m1_lru", {lru_access, lru_addr_access}, {1'b1, 5'd0});
    step();
    chk("m1_valid", entry_valid, 32'h1);
    chk("m1_idle", busy, 1'b0);

    // Fill entries 1..31 in order.
    for (int i = 1; i < 32; i++) begin
      miss(20'(i));
      walk(22'(i + 100), 1'b0);
      chk("fill_widx", {tlb_we, tlb_widx}, {1'b1, 5'(i)});
      step();
    end
    chk("full_valid", entry_valid, 32'hFFFF_FFFF);

    // Hits forward their index to the LRU in the same cycle.
    for (int i = 0; i < 32; i++) begin
      lookup_valid = 1'b1; lookup_hit = 1'b1; hit_idx = 5'(i);
      #1;
      chk("hit_lru", {lru_access, lru_addr_access}, {1'b1, 5'(i)});
      step();
    end
    hit_idx = 5'd0;
    #1;
    chk("hit_busy", busy, 1'b0);
    step();
    lookup_valid = 1'b0; lookup_hit = 1'b0;

    // Full miss goes through SEL/CAPT.
    lookup_valid = 1'b1; lookup_vpn = 20'hABCDE;
    #1;
    chk("fm_nocmp", {lru_compare, lru_access}, 2'b00);
    step();
    lookup_valid = 1'b0;
    chk("fm_sel", {lru_compare, busy, ptw_req_valid}, 3'b110);
    step();
    chk("fm_capt", {lru_compare, ptw_req_valid}, 2'b10);
    step();
    chk("fm_req", {lru_compare, ptw_req_valid}, 2'b01);
    for (int k = 0; k < 5; k++) begin
      ptw_resp_valid = (k == 2);
      ptw_resp_ppn   = 22'h0BAD;
      step();
      ptw_resp_valid = 1'b0;
      chk("stall_req", {ptw_req_valid, ptw_req_vpn}, {1'b1, 20'hABCDE});
    end
    walk(22'h2222, 1'b0);
    chk("fm_fill", {tlb_we, tlb_widx, tlb_wvpn}, {1'b1, 5'd16, 20'hABCDE});
    chk("fm_ppn", {miss_done, tlb_wppn}, {1'b1, 22'h2222});
    step();
    chk("fm_valid", entry_valid, 32'hFFFF_FFFF);

    // Faulting walk.
    miss(20'h55555);
    wait_req();
    walk(22'h55, 1'b1);
    chk("flt_done", {miss_done, miss_fault}, 2'b11);
    chk("flt_nowr", {tlb_we, lru_access}, 2'b00);
    chk("flt_ppn", miss_ppn, 22'h55);
    step();
    chk("flt_valid", entry_valid, 32'hFFFF_FFFF);

    // Flush during WAIT is deferred to FILL.
    miss(20'h66666);
    wait_req();
    ptw_req_ready = 1'b1;
    step();
    ptw_req_ready = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_defer", entry_valid, 32'hFFFF_FFFF);
    ptw_resp_valid = 1'b1; ptw_resp_ppn = 22'h1;
    step();
    ptw_resp_valid = 1'b0;
    chk("fl_fill", {miss_done, miss_fault, tlb_we}, 3'b100);
    chk("fl_ppn", miss_ppn, 22'h1);
    step();
    chk("fl_valid", entry_valid, 32'h0);

    // Flush coinciding with a miss: vector cleared, victim 0.
    miss(20'h777); walk(22'h7, 1'b0); step();
    miss(20'h888); walk(22'h8, 1'b0); step();
    chk("pre_fm", entry_valid, 32'h3);
    flush = 1'b1;
    miss(20'h999);
    flush = 1'b0;
    chk("fm_clr", entry_valid, 32'h0);
    chk("fm_req2", {ptw_req_valid, ptw_req_vpn}, {1'b1, 20'h999});
    walk(22'h9, 1'b0);
    chk("fm_widx", {tlb_we, tlb_widx}, {1'b1, 5'd0});
    step();
    chk("fm_valid2", entry_valid, 32'h1);

    // Reset in WAIT: back to IDLE, late response ignored.
    miss(20'hAAA);
    ptw_req_ready = 1'b1;
    step();
    ptw_req_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rw_busy", busy, 1'b0);
    chk("rw_valid", entry_valid, 32'h0);
    ptw_resp_valid = 1'b1; ptw_resp_ppn = 22'h4;
    #1;
    chk("rw_nowr", {tlb_we, miss_done}, 2'b00);
    step();
    ptw_resp_valid = 1'b0;
    chk("rw_after", {busy, tlb_we, miss_done}, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
